// File: rtl/video_timing_gen_if.sv
// Pixel-stream source bundle: run/pattern controls in, sync/de/pixel timing out.
interface video_timing_gen_if;
  logic       en;
  logic [1:0] pattern_sel;
  logic       hsync;
  logic       vsync;
  logic       de;
  logic [7:0] pixel_out;
  logic       frame_start;

  modport master (input en, pattern_sel,
                  output hsync, vsync, de, pixel_out, frame_start);
  modport slave  (output en, pattern_sel,
                  input hsync, vsync, de, pixel_out, frame_start);
endinterface

// File: rtl/video_timing_gen.sv
// Programmable hsync/vsync/de timing generator with a grey test-pattern pixel source.
// Outputs are registered from the current counter values, one clk behind them.
module video_timing_gen #(
  parameter int H_ACTIVE = 1280,
  parameter int H_FP     = 110,
  parameter int H_SYNC   = 40,
  parameter int H_BP     = 220,
  parameter int V_ACTIVE = 720,
  parameter int V_FP     = 5,
  parameter int V_SYNC   = 5,
  parameter int V_BP     = 20,
  parameter bit SYNC_POL = 1'b1
) (
  input logic               clk,
  input logic               rst,
  video_timing_gen_if.master vid
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  // A one-line frame would otherwise give a zero-width counter.
  localparam int HW = (H_TOTAL > 1) ? $clog2(H_TOTAL) : 1;
  localparam int VW = (V_TOTAL > 1) ? $clog2(V_TOTAL) : 1;

  logic [HW-1:0] h_cnt;
  logic [VW-1:0] v_cnt;
  logic [7:0]    frame_cnt;
  logic [1:0]    pat_q;

  logic [31:0] hx, vx;
  logic        origin, h_last, v_last, h_act, v_act, hs_act, vs_act;
  logic [1:0]  pat_eff;
  logic [7:0]  pix_c;

  assign hx = 32'(h_cnt);
  assign vx = 32'(v_cnt);

  always_comb begin
    origin  = (hx == 0) && (vx == 0);
    h_last  = (hx == H_TOTAL - 1);
    v_last  = (vx == V_TOTAL - 1);
    h_act   = hx < H_ACTIVE;
    v_act   = vx < V_ACTIVE;
    hs_act  = (hx >= H_ACTIVE + H_FP) && (hx < H_ACTIVE + H_FP + H_SYNC);
    vs_act  = (vx >= V_ACTIVE + V_FP) && (vx < V_ACTIVE + V_FP + V_SYNC);
    // The pattern latched at (0,0) already applies to pixel (0,0) itself.
    pat_eff = origin ? vid.pattern_sel : pat_q;
    case (pat_eff)
      2'd0:    pix_c = hx[7:0];
      2'd1:    pix_c = vx[7:0];
      2'd2:    pix_c = (hx[3] ^ vx[3]) ? 8'hFF : 8'h00;
      default: pix_c = frame_cnt;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      h_cnt           <= '0;
      v_cnt           <= '0;
      frame_cnt       <= '0;
      pat_q           <= '0;
      vid.de          <= 1'b0;
      vid.pixel_out   <= '0;
      vid.frame_start <= 1'b0;
      vid.hsync       <= ~SYNC_POL;
      vid.vsync       <= ~SYNC_POL;
    end else if (!vid.en) begin
      h_cnt           <= '0;
      v_cnt           <= '0;
      vid.de          <= 1'b0;
      vid.pixel_out   <= '0;
      vid.frame_start <= 1'b0;
      vid.hsync       <= ~SYNC_POL;
      vid.vsync       <= ~SYNC_POL;
    end else begin
      vid.de          <= h_act && v_act;
      vid.pixel_out   <= (h_act && v_act) ? pix_c : 8'h00;
      vid.frame_start <= origin;
      vid.hsync       <= hs_act ? SYNC_POL : ~SYNC_POL;
      vid.vsync       <= vs_act ? SYNC_POL : ~SYNC_POL;
      if (origin) pat_q <= vid.pattern_sel;
      if (h_last) begin
        h_cnt <= '0;
        if (v_last) begin
          v_cnt     <= '0;
          frame_cnt <= frame_cnt + 8'd1;
        end else begin
          v_cnt <= v_cnt + 1'b1;
        end
      end else begin
        h_cnt <= h_cnt + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_video_timing_gen.sv
// Bench for video_timing_gen: pixel-index reference model plus a one-line-frame stress instance.
module tb_video_timing_gen;
  localparam int HA = 8, HF = 2, HS = 3, HB = 3;
  localparam int VA = 4, VF = 1, VS = 2, VB = 1;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int FT = HT * VT;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  video_timing_gen_if vt();
  video_timing_gen_if vsx();

  video_timing_gen #(.H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
                     .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB), .SYNC_POL(1'b1))
    dut (.clk(clk), .rst(rst), .vid(vt));

  video_timing_gen #(.H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
                     .V_ACTIVE(1), .V_FP(0), .V_SYNC(0), .V_BP(0), .SYNC_POL(1'b1))
    dut_s (.clk(clk), .rst(rst), .vid(vsx));

  int total = 0;
  int bad   = 0;
  // Model: t = pixels emitted since the last restart, fc = frames completed, pat = latched pattern.
  int t = 0, fc = 0, pat = 0;
  logic [11:0] exp_v, got;

  function automatic logic [11:0] model_out(int h, int v, int p, int f);
    logic hs, vs, de, fs;
    logic [7:0] pix;
    hs = (h >= HA + HF) && (h < HA + HF + HS);
    vs = (v >= VA + VF) && (v < VA + VF + VS);
    de = (h < HA) && (v < VA);
    fs = (h == 0) && (v == 0);
    case (p)
      0:       pix = 8'(h % 256);
      1:       pix = 8'(v % 256);
      2:       pix = ((((h / 8) + (v / 8)) % 2) == 1) ? 8'hFF : 8'h00;
      default: pix = 8'(f % 256);
    endcase
    if (!de) pix = 8'h00;
    return {hs, vs, de, pix, fs};
  endfunction

  task automatic step();
    int h, v;
    @(posedge clk);
    if (rst) begin
      t = 0; fc = 0; pat = 0; exp_v = '0;
    end else if (!vt.en) begin
      t = 0; exp_v = '0;
    end else begin
      h = t % HT;
      v = (t / HT) % VT;
      if (h == 0 && v == 0) pat = int'(vt.pattern_sel);
      exp_v = model_out(h, v, pat, fc);
      if (h == HT - 1 && v == VT - 1) fc = (fc + 1) % 256;
      t++;
    end
    #1;
    got = {vt.hsync, vt.vsync, vt.de, vt.pixel_out, vt.frame_start};
  endtask

  task automatic test_reset();
    rst = 1'b1; vt.en = 1'b0; vt.pattern_sel = 2'd0;
    vsx.en = 1'b0; vsx.pattern_sel = 2'd0;
    repeat (3) begin
      step();
      total++;
      if (got !== exp_v) begin bad++; $display("FAIL reset got=%h exp=%h", got, exp_v); end
    end
    rst = 1'b0;
  endtask

  task automatic test_frame_wrap();
    logic [3:0] g, e;
    int h;
    vsx.en = 1'b1; vsx.pattern_sel = 2'd3;
    for (int n = 0; n < 258 * HT; n++) begin
      step();
      h = n % HT;
      g = {vsx.hsync, vsx.vsync, vsx.de, 1'b0};
      e = {(h >= 10 && h <= 12), 1'b0, (h < HA), 1'b0};
      total++;
      if (g !== e || vsx.pixel_out !== ((h < HA) ? 8'((n / HT) % 256) : 8'h00)) begin
        bad++;
        $display("FAIL frame_wrap n=%0d sync/de=%b pix=%h exp_frame=%0d", n, g, vsx.pixel_out, (n / HT) % 256);
      end
    end
    vsx.en = 1'b0;
  endtask

  task automatic test_first_line();
    int de_n = 0, fs_n = 0;
    step();
    vt.en = 1'b1; vt.pattern_sel = 2'd0;
    for (int i = 0; i < HT; i++) begin
      step();
      total++;
      if (got !== exp_v) begin bad++; $display("FAIL first_line i=%0d got=%h exp=%h", i, got, exp_v); end
      total++;
      if (vt.hsync !== (i >= 10 && i <= 12)) begin bad++; $display("FAIL first_hsync i=%0d got=%b", i, vt.hsync); end
      de_n += int'(vt.de);
      fs_n += int'(vt.frame_start);
    end
    total++;
    if (de_n != 8) begin bad++; $display("FAIL first_de_count got=%0d exp=8", de_n); end
    total++;
    if (fs_n != 1) begin bad++; $display("FAIL first_fs_count got=%0d exp=1", fs_n); end
  endtask

  task automatic test_free_run();
    int de_n = 0, vs_n = 0, fs_n = 0;
    while (t % FT != 0) begin
      step();
      total++;
      if (got !== exp_v) begin bad++; $display("FAIL align got=%h exp=%h", got, exp_v); end
    end
    for (int i = 0; i < 3 * FT; i++) begin
      step();
      total++;
      if (got !== exp_v) begin bad++; $display("FAIL free_run i=%0d got=%h exp=%h", i, got, exp_v); end
      de_n += int'(vt.de);
      vs_n += int'(vt.vsync);
      if (vt.frame_start) begin
        fs_n++;
        total++;
        if (i % FT != 0) begin bad++; $display("FAIL fs_period at=%0d exp multiple of %0d", i, FT); end
      end
    end
    total++;
    if (de_n != 96 || vs_n != 96 || fs_n != 3) begin
      bad++; $display("FAIL free_run_counts de=%0d vs=%0d fs=%0d exp 96/96/3", de_n, vs_n, fs_n);
    end
  endtask

  task automatic test_pattern_switch();
    while (t % FT != 0) step();
    vt.pattern_sel = 2'd2;
    for (int i = 0; i < FT + 50; i++) begin
      step();
      total++;
      if (got !== exp_v) begin bad++; $display("FAIL pat2 i=%0d got=%h exp=%h", i, got, exp_v); end
    end
    vt.pattern_sel = 2'd0;
    for (int i = 0; i < 2 * FT; i++) begin
      step();
      total++;
      if (got !== exp_v) begin bad++; $display("FAIL pat_switch i=%0d got=%h exp=%h", i, got, exp_v); end
    end
  endtask

  task automatic test_flat();
    vt.pattern_sel = 2'd3;
    for (int i = 0; i < 3 * FT; i++) begin
      step();
      total++;
      if (got !== exp_v) begin bad++; $display("FAIL flat i=%0d got=%h exp=%h", i, got, exp_v); end
    end
  endtask

  task automatic test_en_drop();
    int k = int'($urandom_range(1, 7));
    vt.pattern_sel = 2'd0;
    while (t % HT != k) step();
    vt.en = 1'b0;
    repeat (5) begin
      step();
      total++;
      if (got !== 12'h000) begin bad++; $display("FAIL en_idle got=%h exp=000", got); end
    end
    vt.en = 1'b1;
    for (int i = 0; i < 40; i++) begin
      step();
      total++;
      if (got !== exp_v) begin bad++; $display("FAIL en_restart i=%0d got=%h exp=%h", i, got, exp_v); end
    end
  endtask

  task automatic test_rst_mid();
    vt.pattern_sel = 2'd2;
    while (t % FT != 2 * HT + 11) step();
    rst = 1'b1;
    step();
    total++;
    if (got !== 12'h000) begin bad++; $display("FAIL rst_mid got=%h exp=000", got); end
    rst = 1'b0;
    vt.pattern_sel = 2'd1;
    for (int i = 0; i < FT; i++) begin
      step();
      total++;
      if (got !== exp_v) begin bad++; $display("FAIL rst_restart i=%0d got=%h exp=%h", i, got, exp_v); end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 2000; i++) begin
      rst   = ($urandom_range(0, 199) == 0);
      vt.en = ($urandom_range(0, 29) != 0);
      if ($urandom_range(0, 19) == 0) vt.pattern_sel = 2'($urandom_range(0, 3));
      step();
      total++;
      if (got !== exp_v) begin bad++; $display("FAIL random i=%0d got=%h exp=%h", i, got, exp_v); end
    end
    rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_frame_wrap();
    test_first_line();
    test_free_run();
    test_pattern_switch();
    test_flat();
    test_en_drop();
    test_rst_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
